// File: rtl/reg_file_scoreboard.sv
// Register file with two registered read ports, one write-back port and a
// per-register pending-write scoreboard. Register 0 reads as zero and is never busy.
module reg_file_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int CNT_W    = $clog2(NUM_REGS) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rs1_idx,
    input  logic [IDX_W-1:0]  rs2_idx,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              issue_en,
    input  logic [IDX_W-1:0]  issue_idx,
    input  logic              wb_en,
    input  logic [IDX_W-1:0]  wb_idx,
    input  logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  pending_cnt
);

    localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    logic [DATA_W-1:0]   regs_r [NUM_REGS];
    logic [NUM_REGS-1:0] busy_r;

    logic                wb_hit_s;
    logic                issue_hit_s;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] clr_mask_s;
    logic [NUM_REGS-1:0] busy_next_s;
    logic [DATA_W-1:0]   rs1_data_next_s;
    logic [DATA_W-1:0]   rs2_data_next_s;
    logic                rs1_busy_next_s;
    logic                rs2_busy_next_s;

    // Next scoreboard state and write-through read values; set is applied after clear so issue wins.
    always_comb begin
        wb_hit_s    = wb_en && (wb_idx != {IDX_W{1'b0}});
        issue_hit_s = issue_en && (issue_idx != {IDX_W{1'b0}});
        set_mask_s  = issue_hit_s ? (ONE_HOT0 << issue_idx) : {NUM_REGS{1'b0}};
        clr_mask_s  = wb_hit_s ? (ONE_HOT0 << wb_idx) : {NUM_REGS{1'b0}};
        busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;

        rs1_data_next_s = (rs1_idx == {IDX_W{1'b0}}) ? {DATA_W{1'b0}} :
                          (wb_hit_s && (wb_idx == rs1_idx)) ? wb_data : regs_r[rs1_idx];
        rs2_data_next_s = (rs2_idx == {IDX_W{1'b0}}) ? {DATA_W{1'b0}} :
                          (wb_hit_s && (wb_idx == rs2_idx)) ? wb_data : regs_r[rs2_idx];
        rs1_busy_next_s = busy_next_s[rs1_idx];
        rs2_busy_next_s = busy_next_s[rs2_idx];
    end

    // State and registered outputs; reset discards all pending writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            busy_r      <= {NUM_REGS{1'b0}};
            pending_cnt <= {CNT_W{1'b0}};
            rs1_data    <= {DATA_W{1'b0}};
            rs2_data    <= {DATA_W{1'b0}};
            rs1_busy    <= 1'b0;
            rs2_busy    <= 1'b0;
        end else begin
            busy_r      <= busy_next_s;
            pending_cnt <= popcount(busy_next_s);
            if (wb_hit_s) begin
                regs_r[wb_idx] <= wb_data;
            end
            if (rd_en) begin
                rs1_data <= rs1_data_next_s;
                rs2_data <= rs2_data_next_s;
                rs1_busy <= rs1_busy_next_s;
                rs2_busy <= rs2_busy_next_s;
            end
        end
    end

endmodule
